// File: rtl/vis_pkg.sv
// Shared constants and helpers for the scanned seven-segment debug display.
// Glyphs are active-high with bit0=a through bit6=g.
package vis_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = SEG_0;
            4'h1: s = SEG_1;
            4'h2: s = SEG_2;
            4'h3: s = SEG_3;
            4'h4: s = SEG_4;
            4'h5: s = SEG_5;
            4'h6: s = SEG_6;
            4'h7: s = SEG_7;
            4'h8: s = SEG_8;
            4'h9: s = SEG_9;
            4'hA: s = SEG_A;
            4'hB: s = SEG_B;
            4'hC: s = SEG_C;
            4'hD: s = SEG_D;
            4'hE: s = SEG_E;
            default: s = SEG_F;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stability counter and rising-edge press pulse
// for one raw push button.
module btn_debounce
    import vis_pkg::*;
#(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int unsigned CW = (clog2(DEB_CYCLES) > 0) ? clog2(DEB_CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic          accepted;
    logic          accepted_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            accepted   <= 1'b0;
            accepted_d <= 1'b0;
            cnt        <= '0;
        end else begin
            sync1      <= btn_raw;
            sync2      <= sync1;
            accepted_d <= accepted;
            if (sync2 == accepted) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                accepted <= ~accepted;
                cnt      <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Edge taken from registered levels so the consumer updates one edge after acceptance.
    assign press = accepted & ~accepted_d;

endmodule

// File: rtl/disp_scan_visual.sv
// Time-multiplexed seven-segment display of several debug channels, with
// paging across channels and a button-controlled freeze snapshot.
module disp_scan_visual
    import vis_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 3,
    parameter int DISP_WIDTH = 7,
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int DEB_CYCLES = 16,
    localparam int NIBBLES   = CHANNELS * WIDTH / 4,
    localparam int PAGES     = (NIBBLES + DIGITS - 1) / DIGITS,
    localparam int PW        = (clog2(PAGES) > 0) ? int'(clog2(PAGES)) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] ch_data,
    input  logic                      page_btn,
    input  logic                      freeze_btn,
    output logic [DISP_WIDTH-1:0]     seg_out,
    output logic [DIGITS-1:0]         dig_en,
    output logic [PW-1:0]             page_idx,
    output logic                      frozen
);

    localparam int unsigned SW = (clog2(SCAN_DIV) > 0) ? clog2(SCAN_DIV) : 1;
    localparam int unsigned DW = (clog2(DIGITS) > 0) ? clog2(DIGITS) : 1;
    localparam int unsigned IW = clog2(PAGES * DIGITS) + 1;

    logic [SW-1:0]             presc;
    logic [DW-1:0]             digit;
    logic [CHANNELS*WIDTH-1:0] snap;
    logic [CHANNELS*WIDTH-1:0] src;
    logic                      page_press;
    logic                      frz_press;
    logic [IW-1:0]             nib_idx;
    logic [3:0]                nibble;
    logic                      nib_valid;
    logic [DISP_WIDTH-1:0]     seg_next;
    logic [DIGITS-1:0]         dig_next;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_page_deb (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(page_btn),
        .press  (page_press)
    );

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_freeze_deb (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(freeze_btn),
        .press  (frz_press)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            digit <= '0;
        end else if (presc == SW'(SCAN_DIV - 1)) begin
            presc <= '0;
            digit <= (digit == DW'(DIGITS - 1)) ? '0 : digit + DW'(1);
        end else begin
            presc <= presc + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            page_idx <= '0;
            frozen   <= 1'b0;
            snap     <= '0;
        end else begin
            if (page_press) begin
                page_idx <= (page_idx == PW'(PAGES - 1)) ? '0 : page_idx + PW'(1);
            end
            if (frz_press) begin
                frozen <= ~frozen;
                if (!frozen) begin
                    snap <= ch_data;
                end
            end
        end
    end

    assign nib_idx = IW'(page_idx) * IW'(DIGITS) + IW'(digit);

    // Indices past the last channel nibble fall through to a blank digit.
    always_comb begin
        src       = frozen ? snap : ch_data;
        nibble    = '0;
        nib_valid = 1'b0;
        for (int unsigned n = 0; n < NIBBLES; n++) begin
            if (nib_idx == IW'(n)) begin
                nibble    = src[n*4 +: 4];
                nib_valid = 1'b1;
            end
        end
        seg_next = nib_valid ? DISP_WIDTH'(hex_to_seg(nibble)) : DISP_WIDTH'(SEG_BLANK);
        dig_next = (presc == '0) ? '0 : (DIGITS'(1) << digit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_out <= '0;
            dig_en  <= '0;
        end else begin
            seg_out <= seg_next;
            dig_en  <= dig_next;
        end
    end

endmodule

// File: tb/tb_disp_scan_visual.sv
// Directed self-checking bench for disp_scan_visual with a 3x8-bit, 4-digit,
// SCAN_DIV=4, DEB_CYCLES=4 configuration.
module tb_disp_scan_visual;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] ch_data;
    logic        page_btn;
    logic        freeze_btn;
    logic [6:0]  seg_out;
    logic [3:0]  dig_en;
    logic [0:0]  page_idx;
    logic        frozen;

    int checks = 0;
    int errors = 0;
    int k      = 0;

    disp_scan_visual #(
        .WIDTH     (8),
        .CHANNELS  (3),
        .DISP_WIDTH(7),
        .DIGITS    (4),
        .SCAN_DIV  (4),
        .DEB_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ch_data   (ch_data),
        .page_btn  (page_btn),
        .freeze_btn(freeze_btn),
        .seg_out   (seg_out),
        .dig_en    (dig_en),
        .page_idx  (page_idx),
        .frozen    (frozen)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // kk = edges since reset release; slot 0 of each digit is dark.
    function automatic logic [3:0] exp_dig(input int kk);
        if ((kk - 1) % 4 == 0) return 4'b0000;
        return 4'b0001 << (((kk - 1) / 4) % 4);
    endfunction

    function automatic int dig_of(input int kk);
        return ((kk - 1) / 4) % 4;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        k = k + 1;
    endtask

    task automatic test_reset();
        logic [6:0] eg [4];
        eg = '{7'h06, 7'h3F, 7'h39, 7'h4F};
        rst = 1'b1; page_btn = 1'b0; freeze_btn = 1'b0; ch_data = 24'hA53C01;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (seg_out !== 7'h00) begin errors++; $display("FAIL reset_seg: got %h expected 00", seg_out); end
        checks++; if (dig_en !== 4'h0) begin errors++; $display("FAIL reset_dig: got %b expected 0000", dig_en); end
        checks++; if (page_idx !== 1'b0) begin errors++; $display("FAIL reset_page: got %b expected 0", page_idx); end
        checks++; if (frozen !== 1'b0) begin errors++; $display("FAIL reset_frozen: got %b expected 0", frozen); end
        rst = 1'b0;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if (dig_en !== exp_dig(k)) begin errors++; $display("FAIL reset_scan_dig k=%0d: got %b expected %b", k, dig_en, exp_dig(k)); end
            if (exp_dig(k) != 4'b0) begin
                checks++;
                if (seg_out !== eg[dig_of(k)]) begin errors++; $display("FAIL reset_scan_seg k=%0d: got %h expected %h", k, seg_out, eg[dig_of(k)]); end
            end
        end
    endtask

    task automatic test_page();
        logic [6:0] eg [4];
        eg = '{7'h6D, 7'h77, 7'h00, 7'h00};
        page_btn = 1'b1;
        repeat (6) tick();
        checks++; if (page_idx !== 1'b0) begin errors++; $display("FAIL page_early: got %b expected 0", page_idx); end
        tick();
        checks++; if (page_idx !== 1'b1) begin errors++; $display("FAIL page_edge7: got %b expected 1", page_idx); end
        repeat (3) tick();
        page_btn = 1'b0;
        repeat (12) tick();
        checks++; if (page_idx !== 1'b1) begin errors++; $display("FAIL page_release: got %b expected 1", page_idx); end
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if (dig_en !== exp_dig(k)) begin errors++; $display("FAIL page1_dig k=%0d: got %b expected %b", k, dig_en, exp_dig(k)); end
            if (exp_dig(k) != 4'b0) begin
                checks++;
                if (seg_out !== eg[dig_of(k)]) begin errors++; $display("FAIL page1_seg k=%0d: got %h expected %h", k, seg_out, eg[dig_of(k)]); end
            end
        end
        page_btn = 1'b1;
        repeat (6) tick();
        checks++; if (page_idx !== 1'b1) begin errors++; $display("FAIL page_wrap_early: got %b expected 1", page_idx); end
        tick();
        checks++; if (page_idx !== 1'b0) begin errors++; $display("FAIL page_wrap: got %b expected 0", page_idx); end
        page_btn = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_freeze();
        logic [6:0] eg [4];
        eg = '{7'h06, 7'h3F, 7'h39, 7'h4F};
        while (k % 4 != 0) tick();
        freeze_btn = 1'b1;
        repeat (6) tick();
        checks++; if (frozen !== 1'b0) begin errors++; $display("FAIL freeze_early: got %b expected 0", frozen); end
        tick();
        checks++; if (frozen !== 1'b1) begin errors++; $display("FAIL freeze_edge7: got %b expected 1", frozen); end
        repeat (2) tick();
        freeze_btn = 1'b0;
        ch_data = 24'hFFFFFF;
        repeat (12) tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if (dig_en !== exp_dig(k)) begin errors++; $display("FAIL frozen_dig k=%0d: got %b expected %b", k, dig_en, exp_dig(k)); end
            if (exp_dig(k) != 4'b0) begin
                checks++;
                if (seg_out !== eg[dig_of(k)]) begin errors++; $display("FAIL frozen_seg k=%0d: got %h expected %h", k, seg_out, eg[dig_of(k)]); end
            end
        end
        while (k % 4 != 0) tick();
        freeze_btn = 1'b1;
        repeat (6) tick();
        checks++; if (frozen !== 1'b1) begin errors++; $display("FAIL unfreeze_early: got %b expected 1", frozen); end
        tick();
        checks++; if (frozen !== 1'b0) begin errors++; $display("FAIL unfreeze_edge7: got %b expected 0", frozen); end
        tick();
        checks++; if (dig_en !== exp_dig(k)) begin errors++; $display("FAIL unfreeze_dig: got %b expected %b", dig_en, exp_dig(k)); end
        checks++; if (seg_out !== 7'h71) begin errors++; $display("FAIL unfreeze_live_seg: got %h expected 71", seg_out); end
        freeze_btn = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_bounce();
        for (int len = 1; len <= 3; len++) begin
            page_btn = 1'b1;
            repeat (len) tick();
            page_btn = 1'b0;
            repeat (8) tick();
            checks++;
            if (page_idx !== 1'b0) begin errors++; $display("FAIL bounce_len%0d: got %b expected 0", len, page_idx); end
        end
    endtask

    task automatic test_back_to_back();
        page_btn = 1'b1;
        freeze_btn = 1'b1;
        repeat (6) tick();
        checks++; if (page_idx !== 1'b0) begin errors++; $display("FAIL both_page_early: got %b expected 0", page_idx); end
        checks++; if (frozen !== 1'b0) begin errors++; $display("FAIL both_frozen_early: got %b expected 0", frozen); end
        tick();
        checks++; if (page_idx !== 1'b1) begin errors++; $display("FAIL both_page: got %b expected 1", page_idx); end
        checks++; if (frozen !== 1'b1) begin errors++; $display("FAIL both_frozen: got %b expected 1", frozen); end
        repeat (2) tick();
        page_btn = 1'b0;
        freeze_btn = 1'b0;
        repeat (13) tick();
    endtask

    task automatic test_reset_midslot();
        logic [6:0] eg [4];
        eg = '{7'h7D, 7'h6D, 7'h66, 7'h4F};
        while (k % 4 != 2) tick();
        #3;
        rst = 1'b1;
        #1;
        checks++; if (seg_out !== 7'h00) begin errors++; $display("FAIL midrst_seg: got %h expected 00", seg_out); end
        checks++; if (dig_en !== 4'h0) begin errors++; $display("FAIL midrst_dig: got %b expected 0000", dig_en); end
        checks++; if (page_idx !== 1'b0) begin errors++; $display("FAIL midrst_page: got %b expected 0", page_idx); end
        checks++; if (frozen !== 1'b0) begin errors++; $display("FAIL midrst_frozen: got %b expected 0", frozen); end
        ch_data = 24'h123456;
        @(posedge clk);
        #1;
        rst = 1'b0;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if (dig_en !== exp_dig(k)) begin errors++; $display("FAIL postrst_dig k=%0d: got %b expected %b", k, dig_en, exp_dig(k)); end
            if (exp_dig(k) != 4'b0) begin
                checks++;
                if (seg_out !== eg[dig_of(k)]) begin errors++; $display("FAIL postrst_seg k=%0d: got %h expected %h", k, seg_out, eg[dig_of(k)]); end
            end
        end
        checks++; if (page_idx !== 1'b0) begin errors++; $display("FAIL postrst_page: got %b expected 0", page_idx); end
        checks++; if (frozen !== 1'b0) begin errors++; $display("FAIL postrst_frozen: got %b expected 0", frozen); end
    endtask

    initial begin
        test_reset();
        test_page();
        test_freeze();
        test_bounce();
        test_back_to_back();
        test_reset_midslot();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
